// File: rtl/shift_register_universal.sv
// Universal shift register: STEP-bit shift/rotate left/right, parallel load, clear,
// plus a frame counter that pulses o_word_valid when a full word has been shifted in.
module shift_register_universal #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  input  logic [2:0]           i_mode,
  input  logic [STEP-1:0]      i_ser_data,
  input  logic [WIDTH-1:0]     i_par_data,
  output logic [WIDTH-1:0]     o_data,
  output logic [STEP-1:0]      o_ser_msb,
  output logic [STEP-1:0]      o_ser_lsb,
  output logic [$clog2(WIDTH/STEP)-1:0] o_count,
  output logic                 o_word_valid
);

  localparam int WORDS = WIDTH / STEP;
  localparam int CNT_W = $clog2(WORDS);

  typedef enum logic [2:0] {
    M_HOLD  = 3'd0,
    M_SHL   = 3'd1,
    M_SHR   = 3'd2,
    M_ROL   = 3'd3,
    M_ROR   = 3'd4,
    M_LOAD  = 3'd5,
    M_CLEAR = 3'd6,
    M_RSVD  = 3'd7
  } mode_e;

  logic [WIDTH-1:0] data_d, data_q;
  logic [CNT_W-1:0] cnt_d,  cnt_q;
  logic             wv_d,   wv_q;
  logic             shift_in;

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    wv_d     = 1'b0;
    shift_in = 1'b0;
    if (i_enable) begin
      case (mode_e'(i_mode))
        M_SHL: begin
          data_d   = {data_q[WIDTH-STEP-1:0], i_ser_data};
          shift_in = 1'b1;
        end
        M_SHR: begin
          data_d   = {i_ser_data, data_q[WIDTH-1:STEP]};
          shift_in = 1'b1;
        end
        M_ROL:   data_d = {data_q[WIDTH-STEP-1:0], data_q[WIDTH-1 -: STEP]};
        M_ROR:   data_d = {data_q[STEP-1:0], data_q[WIDTH-1:STEP]};
        M_LOAD: begin
          data_d = i_par_data;
          cnt_d  = '0;
        end
        M_CLEAR: begin
          data_d = '0;
          cnt_d  = '0;
        end
        default: ;
      endcase
    end
    // Both shift directions feed the same frame counter; no direction tracking.
    if (shift_in) begin
      if (cnt_q == CNT_W'(WORDS - 1)) begin
        cnt_d = '0;
        wv_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      wv_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      wv_q   <= wv_d;
    end
  end

  assign o_data       = data_q;
  assign o_ser_msb    = data_q[WIDTH-1 -: STEP];
  assign o_ser_lsb    = data_q[STEP-1:0];
  assign o_count      = cnt_q;
  assign o_word_valid = wv_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench: instance a is 8-bit/1-bit-step, instance b is 8-bit/2-bit-step.
module tb_shift_register_universal;

  localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                         ROR = 3'd4, LOAD = 3'd5, CLR = 3'd6, RSVD = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_en;
  logic [2:0] a_mode;
  logic [0:0] a_ser;
  logic [7:0] a_par, a_data;
  logic [0:0] a_msb, a_lsb;
  logic [2:0] a_cnt;
  logic       a_wv;

  logic       b_rst_n, b_en;
  logic [2:0] b_mode;
  logic [1:0] b_ser;
  logic [7:0] b_par, b_data;
  logic [1:0] b_msb, b_lsb;
  logic [1:0] b_cnt;
  logic       b_wv;

  int n_tests = 0;
  int n_fail  = 0;

  shift_register_universal #(.WIDTH(8), .STEP(1)) u_a (
    .clk(clk), .i_rst_n(a_rst_n), .i_enable(a_en), .i_mode(a_mode),
    .i_ser_data(a_ser), .i_par_data(a_par), .o_data(a_data),
    .o_ser_msb(a_msb), .o_ser_lsb(a_lsb), .o_count(a_cnt), .o_word_valid(a_wv)
  );

  shift_register_universal #(.WIDTH(8), .STEP(2)) u_b (
    .clk(clk), .i_rst_n(b_rst_n), .i_enable(b_en), .i_mode(b_mode),
    .i_ser_data(b_ser), .i_par_data(b_par), .o_data(b_data),
    .o_ser_msb(b_msb), .o_ser_lsb(b_lsb), .o_count(b_cnt), .o_word_valid(b_wv)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked at the same point.
  task automatic cyc_a(input logic en, input logic [2:0] mode, input logic ser, input logic [7:0] par);
    a_en = en; a_mode = mode; a_ser = ser; a_par = par;
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input logic en, input logic [2:0] mode, input logic [1:0] ser);
    b_en = en; b_mode = mode; b_ser = ser; b_par = 8'h00;
    @(posedge clk); #1;
  endtask

  int pulses, first_p, last_p;
  logic [1:0] chunks [4];
  logic [7:0] exp_d [4];

  initial begin
    a_rst_n = 1'b0; a_en = 1'b0; a_mode = HOLD; a_ser = '0; a_par = '0;
    b_rst_n = 1'b0; b_en = 1'b0; b_mode = HOLD; b_ser = '0; b_par = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_data", 64'(a_data), 0);
    chk("rst_a_cnt",  64'(a_cnt),  0);
    chk("rst_a_wv",   64'(a_wv),   0);
    chk("rst_b_data", 64'(b_data), 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    // asynchronous reset mid-cycle
    cyc_a(1, LOAD, 0, 8'hA5);
    chk("load_a5", 64'(a_data), 8'hA5);
    cyc_a(1, SHL, 1, 8'h00);
    chk("shl_after_load", 64'(a_data), 8'h4B);
    chk("cnt_after_shl",  64'(a_cnt),  1);
    a_en = 1'b0;
    #2 a_rst_n = 1'b0;
    #1;
    chk("async_rst_data", 64'(a_data), 0);
    chk("async_rst_cnt",  64'(a_cnt),  0);
    chk("async_rst_wv",   64'(a_wv),   0);
    @(posedge clk); #1;
    a_rst_n = 1'b1;

    // deserialise, STEP=2
    chunks = '{2'b11, 2'b01, 2'b10, 2'b00};
    exp_d  = '{8'h03, 8'h0D, 8'h36, 8'hD8};
    for (int i = 0; i < 4; i++) begin
      cyc_b(1, SHL, chunks[i]);
      chk($sformatf("deser_data%0d", i), 64'(b_data), exp_d[i]);
      chk($sformatf("deser_cnt%0d", i),  64'(b_cnt),  (i + 1) % 4);
      chk($sformatf("deser_wv%0d", i),   64'(b_wv),   i == 3);
    end

    // continuous stream of 12 shifts
    pulses = 0; first_p = -1; last_p = -1;
    for (int i = 0; i < 12; i++) begin
      cyc_b(1, SHL, 2'(i));
      if (b_wv) begin
        pulses++;
        if (first_p < 0) first_p = i;
        last_p = i;
      end
    end
    chk("stream_pulses", 64'(pulses), 3);
    chk("stream_first",  64'(first_p), 3);
    chk("stream_span",   64'(last_p - first_p), 8);
    cyc_b(0, SHL, 2'b11);
    chk("stream_wv_idle", 64'(b_wv), 0);

    // rotate and serialise, STEP=1
    cyc_a(1, LOAD, 0, 8'h81);
    chk("rot_load",  64'(a_data), 8'h81);
    cyc_a(1, ROL, 0, 8'h00);
    chk("rol",       64'(a_data), 8'h03);
    cyc_a(1, ROR, 1, 8'h00);
    chk("ror1",      64'(a_data), 8'h81);
    cyc_a(1, ROR, 1, 8'h00);
    chk("ror2",      64'(a_data), 8'hC0);
    chk("rot_cnt",   64'(a_cnt),  0);
    cyc_a(1, LOAD, 0, 8'h81);
    chk("ser_msb",   64'(a_msb), 1);
    chk("ser_lsb0",  64'(a_lsb), 1);
    cyc_a(1, SHR, 0, 8'h00);
    chk("ser_lsb1",  64'(a_lsb), 0);
    chk("shr_data1", 64'(a_data), 8'h40);
    cyc_a(1, SHR, 0, 8'h00);
    chk("shr_data2", 64'(a_data), 8'h20);
    chk("shr_cnt",   64'(a_cnt),  2);

    // enable low holds
    cyc_a(1, CLR, 0, 8'h00);
    chk("clr_data", 64'(a_data), 0);
    chk("clr_cnt",  64'(a_cnt),  0);
    cyc_a(1, SHL, 1, 8'h00);
    cyc_a(1, SHL, 0, 8'h00);
    cyc_a(1, SHL, 1, 8'h00);
    chk("pre_hold_data", 64'(a_data), 8'h05);
    for (int i = 0; i < 5; i++) begin
      cyc_a(0, SHL, 1'(i), 8'hFF);
      chk($sformatf("hold_data%0d", i), 64'(a_data), 8'h05);
      chk($sformatf("hold_cnt%0d", i),  64'(a_cnt),  3);
      chk($sformatf("hold_wv%0d", i),   64'(a_wv),   0);
    end
    exp_d = '{8'h0B, 8'h17, 8'h2F, 8'h5F};
    for (int i = 0; i < 5; i++) begin
      cyc_a(1, SHL, 1, 8'h00);
      chk($sformatf("resume_wv%0d", i),  64'(a_wv),  i == 4);
      chk($sformatf("resume_cnt%0d", i), 64'(a_cnt), (4 + i) % 8);
      if (i < 4) chk($sformatf("resume_data%0d", i), 64'(a_data), exp_d[i]);
    end
    chk("resume_final", 64'(a_data), 8'hBF);

    // load mid-word resets the frame
    for (int i = 0; i < 5; i++) cyc_a(1, SHL, 0, 8'h00);
    chk("mid_cnt", 64'(a_cnt), 5);
    cyc_a(1, LOAD, 0, 8'h3C);
    chk("mid_load_data", 64'(a_data), 8'h3C);
    chk("mid_load_cnt",  64'(a_cnt),  0);
    chk("mid_load_wv",   64'(a_wv),   0);
    pulses = 0; last_p = -1;
    for (int i = 0; i < 8; i++) begin
      cyc_a(1, SHL, 0, 8'h00);
      if (a_wv) begin pulses++; last_p = i; end
    end
    chk("mid_pulses", 64'(pulses), 1);
    chk("mid_pulse_at", 64'(last_p), 7);

    // reserved mode and hold mode are no-ops, clear zeros
    cyc_a(1, LOAD, 0, 8'hA5);
    cyc_a(1, SHL, 1, 8'h00);
    cyc_a(1, RSVD, 0, 8'hFF);
    chk("rsvd_data", 64'(a_data), 8'h4B);
    chk("rsvd_cnt",  64'(a_cnt),  1);
    cyc_a(1, HOLD, 0, 8'hFF);
    chk("hold_mode_data", 64'(a_data), 8'h4B);
    cyc_a(1, CLR, 1, 8'hFF);
    chk("clear_data", 64'(a_data), 0);
    chk("clear_cnt",  64'(a_cnt),  0);
    chk("clear_wv",   64'(a_wv),   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
Name: shift_register_universal

Overview:
- Parametrised successor to the fixed 64-bit serial-in shift register used in the datapath.
- Features: configurable width and bits-per-shift, left/right shift and rotate, parallel load, synchronous clear, and hold on enable low.
- Frame counter pulses `o_word_valid` each time a full word has been shifted in, so the block can act as a serial-to-parallel deserialiser.
- Sits between serial link front-ends and word-wide consumers; also serves as a parallel-to-serial converter through the serial-out ports.

Parameters:
- WIDTH, 64, register width in bits; must be a multiple of STEP.
- STEP, 1, bits shifted per enabled shift cycle; 1 <= STEP <= WIDTH/2.
- Localparam WORDS = WIDTH/STEP, the number of shifts per word.
- Localparam CNT_W = $clog2(WORDS).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  operation enable; low = hold everything.
- i_mode  input  3  operation select, sampled when i_enable=1.
- i_ser_data  input  STEP  serial input chunk.
- i_par_data  input  WIDTH  parallel load value.
- o_data  output  WIDTH  register contents (registered).
- o_ser_msb  output  STEP  o_data[WIDTH-1 -: STEP], combinational from the register.
- o_ser_lsb  output  STEP  o_data[STEP-1:0], combinational from the register.
- o_count  output  CNT_W  shifts accumulated in the current word.
- o_word_valid  output  1  one-cycle pulse when a word completes.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (i_rst_n=0, asynchronous, any time):
  - o_data=0, o_count=0, o_word_valid=0.
  - A shift in progress is discarded, with no partial pulse afterwards.
  - Deassertion is sampled at the next rising edge.
- All state updates on the rising edge of clk; latency is 1 cycle from input to o_data.
- i_enable=0: o_data and o_count hold, o_word_valid=0. This is hold, not clear.
- i_mode, applied when i_enable=1:
  - 0 HOLD: no change.
  - 1 SHL: o_data <= {o_data[WIDTH-STEP-1:0], i_ser_data}.
  - 2 SHR: o_data <= {i_ser_data, o_data[WIDTH-1:STEP]}.
  - 3 ROL: o_data <= {o_data[WIDTH-STEP-1:0], o_data[WIDTH-1 -: STEP]}; i_ser_data ignored.
  - 4 ROR: o_data <= {o_data[STEP-1:0], o_data[WIDTH-1:STEP]}.
  - 5 LOAD: o_data <= i_par_data.
  - 6 CLEAR: o_data <= 0.
  - 7: reserved, behaves as HOLD.
- Frame counter:
  - Increments only on SHL or SHR.
  - When o_count = WORDS-1 and a SHL/SHR occurs: o_count wraps to 0 and o_word_valid=1 in the same cycle o_data shows the completed word.
  - o_word_valid is 0 in all other cycles and never stays high two cycles without two completing shifts.
  - Back-to-back words produce pulses exactly WORDS cycles apart.
  - LOAD and CLEAR set o_count=0 with no pulse.
  - ROL, ROR, HOLD and i_enable=0 leave o_count unchanged.
- Mixing directions: SHL and SHR both advance the same counter. No direction tracking is performed.
- Serial-out ports give the chunk that the next SHL (o_ser_msb) or SHR (o_ser_lsb) will eject. For LSB-first transmit, load then SHR.
- No combinational path from inputs to any output.

Test Plan:
- Reset: WIDTH=8, STEP=1; load 0xA5, then assert i_rst_n=0 mid-cycle -> o_data=0x00 and o_count=0 immediately, without waiting for a clock edge; o_word_valid=0.
- Deserialise: WIDTH=8, STEP=2; SHL chunks 2'b11, 2'b01, 2'b10, 2'b00 on consecutive cycles -> o_data=0xD8, o_count 1,2,3,0, o_word_valid high only on the 4th cycle.
- Continuous stream: WIDTH=8, STEP=2, 12 consecutive SHL -> o_word_valid pulses exactly 3 times, 4 cycles apart.
- Rotate/serialise: WIDTH=8, STEP=1; LOAD 0x81, then ROL -> 0x03, ROR twice -> 0xC0, o_count stays 0; LOAD 0x81 then SHR with i_ser_data=0 -> o_ser_lsb sequence 1,0,0,... .
- Enable/hold: WIDTH=8, STEP=1; 3 SHL, then i_enable=0 for 5 cycles with mode=1 toggling i_ser_data -> o_data and o_count=3 frozen; resume 5 SHL -> pulse on the 5th.
- Load mid-word: WIDTH=8, STEP=1; 5 SHL, then LOAD 0x3C -> o_data=0x3C, o_count=0, no pulse; the next 8 SHL give exactly one pulse. Mode 7 and CLEAR: CLEAR -> o_data=0, mode 7 -> no change.
